match_referee: RTL and testbench

Parametrised round/match referee for the tug-of-war game. It watches a playfield LED vector of configurable width and the players' press pulses, and awards a point when the end LED on a player's side is lit and that player presses alone. It keeps per-player scores and drives the score HEX displays. It enforces an inter-round gap and ends the match at a configurable winning score, holding the result until an explicit restart.

---
 rtl/match_referee.sv | 225 ++++++++++++++++++++++
 tb/tb_match_referee.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_referee.sv
// match_referee
// -------------
// Round and match referee for the tug-of-war game.  It watches the playfield
// LED vector and the two players' press pulses, awards a point when a player
// presses alone while the end LED on that player's side is lit, keeps both
// scores, drives the two score displays, and enforces a freeze gap between
// rounds.  When a player reaches WIN_SCORE the match ends and the result is
// held until a restart pulse arrives.
//
// Parameters
//   NUM_LEDS   playfield width (>= 2); field[NUM_LEDS-1] is the leftmost LED
//   WIN_SCORE  points needed to win (1..9)
//   SCORE_W    score register width, 2**SCORE_W > WIN_SCORE
//   ROUND_GAP  cycles round_reset is held after a non-final point (>= 1)
//
// Ports
//   Clock        in   rising-edge clock
//   Reset        in   synchronous active-high reset
//   field        in   playfield LED state
//   L, R         in   one-cycle press pulses, left and right player
//   restart      in   one-cycle pulse, starts a new match from DONE only
//   left_point   out  one-cycle pulse after a left point
//   right_point  out  one-cycle pulse after a right point
//   round_reset  out  level, asks the playfield to re-centre and freeze
//   left_score   out  left score, binary
//   right_score  out  right score, binary
//   HEX5         out  active-low 7-segment image of left_score (g..a)
//   HEX0         out  active-low 7-segment image of right_score (g..a)
//   match_over   out  high while the match is finished
//   winner       out  2'b10 left won, 2'b01 right won, 2'b00 undecided

module match_referee #(
  parameter int NUM_LEDS  = 9,
  parameter int WIN_SCORE = 7,
  parameter int SCORE_W   = 4,
  parameter int ROUND_GAP = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_LEDS-1:0] field,
  input  logic                L,
  input  logic                R,
  input  logic                restart,
  output logic                left_point,
  output logic                right_point,
  output logic                round_reset,
  output logic [SCORE_W-1:0]  left_score,
  output logic [SCORE_W-1:0]  right_score,
  output logic [6:0]          HEX5,
  output logic [6:0]          HEX0,
  output logic                match_over,
  output logic [1:0]          winner
);

  // The gap counter holds "cycles still to go after this one", so it only
  // ever needs to represent ROUND_GAP-1.
  localparam int GAP_W = (ROUND_GAP > 1) ? $clog2(ROUND_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(ROUND_GAP - 1);
  localparam logic [SCORE_W-1:0] MATCH_BALL = SCORE_W'(WIN_SCORE - 1);

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] left_score_q, left_score_d;
  logic [SCORE_W-1:0] right_score_q, right_score_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               left_point_q, left_point_d;
  logic               right_point_q, right_point_d;
  logic               round_reset_q, round_reset_d;
  logic               match_over_q, match_over_d;
  logic [1:0]         winner_q, winner_d;

  logic left_end;
  logic right_end;
  logic left_hit;
  logic right_hit;

  // Only the two end LEDs matter to the referee; the interior of the field
  // is folded into a deliberately unused net.
  logic field_unused;
  assign field_unused = ^field;

  assign left_end  = field[NUM_LEDS-1];
  assign right_end = field[0];

  // A point needs a lone press on the side whose end LED is lit.  Both
  // players pressing together, or both end LEDs lit at once, never scores.
  assign left_hit  = left_end  & L & ~R & ~right_end;
  assign right_hit = right_end & R & ~L & ~left_end;

  // Next-state logic.  Registers hold by default and the point pulses fall
  // back to zero, so every branch below only names what changes.
  always_comb begin
    state_d       = state_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    gap_cnt_d     = gap_cnt_q;
    left_point_d  = 1'b0;
    right_point_d = 1'b0;
    round_reset_d = round_reset_q;
    match_over_d  = match_over_q;
    winner_d      = winner_q;

    case (state_q)
      ST_PLAY: begin
        if (left_hit) begin
          left_score_d  = left_score_q + 1'b1;
          left_point_d  = 1'b1;
          round_reset_d = 1'b1;
          if (left_score_q == MATCH_BALL) begin
            state_d      = ST_DONE;
            match_over_d = 1'b1;
            winner_d     = 2'b10;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end else if (right_hit) begin
          right_score_d = right_score_q + 1'b1;
          right_point_d = 1'b1;
          round_reset_d = 1'b1;
          if (right_score_q == MATCH_BALL) begin
            state_d      = ST_DONE;
            match_over_d = 1'b1;
            winner_d     = 2'b01;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end

      // round_reset was raised on the edge that entered the gap; it is
      // dropped on the edge where the counter has run out, which is the
      // same edge that hands control back to PLAY.
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d       = ST_PLAY;
          round_reset_d = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      // The finished match is frozen.  A restart clears the result and goes
      // through a normal gap so the playfield gets its re-centre time.
      ST_DONE: begin
        if (restart) begin
          state_d       = ST_GAP;
          gap_cnt_d     = GAP_LOAD;
          left_score_d  = '0;
          right_score_d = '0;
          winner_d      = 2'b00;
          match_over_d  = 1'b0;
          round_reset_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  // State register with synchronous reset that overrides everything,
  // abandoning any gap or finished match in progress.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_PLAY;
      left_score_q  <= '0;
      right_score_q <= '0;
      gap_cnt_q     <= '0;
      left_point_q  <= 1'b0;
      right_point_q <= 1'b0;
      round_reset_q <= 1'b0;
      match_over_q  <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      gap_cnt_q     <= gap_cnt_d;
      left_point_q  <= left_point_d;
      right_point_q <= right_point_d;
      round_reset_q <= round_reset_d;
      match_over_q  <= match_over_d;
      winner_q      <= winner_d;
    end
  end

  // Active-low segment patterns, bit order g..a.  Scores above 9 cannot
  // occur, so anything else blanks the digit.
  function automatic logic [6:0] seg7(input logic [SCORE_W-1:0] value);
    int unsigned idx;
    idx = 32'(value);
    case (idx)
      32'd0:   seg7 = 7'b1000000;
      32'd1:   seg7 = 7'b1111001;
      32'd2:   seg7 = 7'b0100100;
      32'd3:   seg7 = 7'b0110000;
      32'd4:   seg7 = 7'b0011001;
      32'd5:   seg7 = 7'b0010010;
      32'd6:   seg7 = 7'b0000010;
      32'd7:   seg7 = 7'b1111000;
      32'd8:   seg7 = 7'b0000000;
      32'd9:   seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign left_point  = left_point_q;
  assign right_point = right_point_q;
  assign round_reset = round_reset_q;
  assign left_score  = left_score_q;
  assign right_score = right_score_q;
  assign match_over  = match_over_q;
  assign winner      = winner_q;
  assign HEX5        = seg7(left_score_q);
  assign HEX0        = seg7(right_score_q);

endmodule

// File: tb/tb_match_referee.sv
// Testbench for match_referee.  Two instances share the clock: "dut" uses
// the default parameters, "dut_w" uses WIN_SCORE=3 for the match-end and
// restart scenario.  Inputs change on the falling edge; outputs are sampled
// on the falling edge after the rising edge that consumed them.  Expected
// output snapshots are queued as stimulus is driven and popped when the
// corresponding cycle's outputs are available.

module tb_match_referee;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Default-parameter instance
  logic       Reset, L, R, restart;
  logic [8:0] field;
  logic       left_point, right_point, round_reset, match_over;
  logic [1:0] winner;
  logic [3:0] left_score, right_score;
  logic [6:0] HEX5, HEX0;

  // WIN_SCORE=3 instance
  logic       Reset_w, L_w, R_w, restart_w;
  logic [8:0] field_w;
  logic       left_point_w, right_point_w, round_reset_w, match_over_w;
  logic [1:0] winner_w;
  logic [3:0] left_score_w, right_score_w;
  logic [6:0] HEX5_w, HEX0_w;

  match_referee dut (
    .Clock(Clock), .Reset(Reset), .field(field), .L(L), .R(R), .restart(restart),
    .left_point(left_point), .right_point(right_point), .round_reset(round_reset),
    .left_score(left_score), .right_score(right_score), .HEX5(HEX5), .HEX0(HEX0),
    .match_over(match_over), .winner(winner)
  );

  match_referee #(.WIN_SCORE(3)) dut_w (
    .Clock(Clock), .Reset(Reset_w), .field(field_w), .L(L_w), .R(R_w), .restart(restart_w),
    .left_point(left_point_w), .right_point(right_point_w), .round_reset(round_reset_w),
    .left_score(left_score_w), .right_score(right_score_w), .HEX5(HEX5_w), .HEX0(HEX0_w),
    .match_over(match_over_w), .winner(winner_w)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [27:0] exp_q[$];
  logic [27:0] got, want;

  // Reference segment table, active-low, g..a
  function automatic logic [6:0] seg(input int v);
    case (v)
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // Snapshot layout: {lp, rp, rr, mo, winner[1:0], ls[3:0], rs[3:0], HEX5, HEX0}
  function automatic logic [27:0] pack(input logic lp, input logic rp, input logic rr,
                                       input logic mo, input logic [1:0] win,
                                       input int ls, input int rs);
    pack = {lp, rp, rr, mo, win, 4'(ls), 4'(rs), seg(ls), seg(rs)};
  endfunction

  function automatic logic [27:0] obs_main();
    obs_main = {left_point, right_point, round_reset, match_over, winner,
                left_score, right_score, HEX5, HEX0};
  endfunction

  function automatic logic [27:0] obs_w();
    obs_w = {left_point_w, right_point_w, round_reset_w, match_over_w, winner_w,
             left_score_w, right_score_w, HEX5_w, HEX0_w};
  endfunction

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic drive_main(input logic [8:0] f, input logic l, input logic r, input logic rs);
    field = f; L = l; R = r; restart = rs;
  endtask

  task automatic drive_w(input logic [8:0] f, input logic l, input logic r, input logic rs);
    field_w = f; L_w = l; R_w = r; restart_w = rs;
  endtask

  // Reset must win over a qualifying left hit presented at the same edge.
  task automatic test_reset();
    Reset = 1'b1;
    drive_main(9'h100, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pack(0, 0, 0, 0, 2'b00, 0, 0));
    tick();
    got = obs_main(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL reset: got %h want %h", got, want);
    end
    Reset = 1'b0;
    drive_main(9'h000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_left_point();
    drive_main(9'h100, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pack(1, 0, 1, 0, 2'b00, 1, 0));
    tick();
    got = obs_main(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL left_point: got %h want %h", got, want);
    end
  endtask

  // Four gap cycles follow the point; a right hit plus restart arrive in
  // the first of them and must be ignored.  The fourth edge reopens PLAY.
  task automatic test_gap_ignores();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive_main(9'h001, 1'b0, 1'b1, 1'b1);
      else        drive_main(9'h000, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(pack(0, 0, (i < 3), 0, 2'b00, 1, 0));
      tick();
      got = obs_main(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL gap_cycle%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  // Non-qualifying patterns in PLAY, including restart outside DONE.
  task automatic test_no_score();
    logic [8:0] f_tab [7] = '{9'h100, 9'h101, 9'h101, 9'h001, 9'h100, 9'h000, 9'h000};
    logic       l_tab [7] = '{1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0};
    logic       r_tab [7] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
    logic       s_tab [7] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
    for (int i = 0; i < 7; i++) begin
      drive_main(f_tab[i], l_tab[i], r_tab[i], s_tab[i]);
      exp_q.push_back(pack(0, 0, 0, 0, 2'b00, 1, 0));
      tick();
      got = obs_main(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL no_score%0d: got %h want %h", i, got, want);
      end
    end
    drive_main(9'h000, 1'b0, 1'b0, 1'b0);
  endtask

  // Score a left point, then reset on the second gap cycle; the next cycle
  // is PLAY with cleared scores and a right hit scores immediately.
  task automatic test_reset_mid_gap();
    logic [27:0] exp_tab [8];
    exp_tab[0] = pack(1, 0, 1, 0, 2'b00, 2, 0);
    exp_tab[1] = pack(0, 0, 1, 0, 2'b00, 2, 0);
    exp_tab[2] = pack(0, 0, 0, 0, 2'b00, 0, 0);
    exp_tab[3] = pack(0, 1, 1, 0, 2'b00, 0, 1);
    exp_tab[4] = pack(0, 0, 1, 0, 2'b00, 0, 1);
    exp_tab[5] = pack(0, 0, 1, 0, 2'b00, 0, 1);
    exp_tab[6] = pack(0, 0, 1, 0, 2'b00, 0, 1);
    exp_tab[7] = pack(0, 0, 0, 0, 2'b00, 0, 1);
    for (int i = 0; i < 8; i++) begin
      Reset = (i == 2);
      case (i)
        0:       drive_main(9'h100, 1'b1, 1'b0, 1'b0);
        3:       drive_main(9'h001, 1'b0, 1'b1, 1'b0);
        default: drive_main(9'h000, 1'b0, 1'b0, 1'b0);
      endcase
      exp_q.push_back(exp_tab[i]);
      tick();
      got = obs_main(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_gap%0d: got %h want %h", i, got, want);
      end
    end
    Reset = 1'b0;
    drive_main(9'h000, 1'b0, 1'b0, 1'b0);
  endtask

  // Seven right points to the default winning score, then a frozen DONE
  // that ignores a qualifying left hit.
  task automatic test_seven_right();
    int rp_count = 0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      for (int c = 0; c < 5; c++) begin
        if (c == 0) begin
          drive_main(9'h001, 1'b0, 1'b1, 1'b0);
          exp_q.push_back(pack(0, 1, 1, (i == 7), (i == 7) ? 2'b01 : 2'b00, 0, i));
        end else begin
          drive_main(9'h000, 1'b0, 1'b0, 1'b0);
          exp_q.push_back(pack(0, 0, (c < 4), 0, 2'b00, 0, i));
        end
        tick();
        rp_count += int'(right_point);
        got = obs_main(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
          miscompares++;
          $display("[TB] FAIL right_run%0d_c%0d: got %h want %h", i, c, got, want);
        end
        if (i == 7) break;
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive_main(9'h100, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(pack(0, 0, 1, 1, 2'b01, 0, 7));
      tick();
      rp_count += int'(right_point);
      got = obs_main(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL done_frozen%0d: got %h want %h", c, got, want);
      end
    end
    drive_main(9'h000, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rp_count !== 7) begin
      miscompares++;
      $display("[TB] FAIL right_pulse_count: got %0d want 7", rp_count);
    end
  endtask

  // WIN_SCORE=3: three left points end the match; DONE ignores hits;
  // restart clears, runs a four-cycle gap, then PLAY scores again.
  task automatic test_win_and_restart();
    Reset_w = 1'b1;
    drive_w(9'h000, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(pack(0, 0, 0, 0, 2'b00, 0, 0));
    tick();
    got = obs_w(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL w_reset: got %h want %h", got, want);
    end
    Reset_w = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      for (int c = 0; c < 5; c++) begin
        if (c == 0) begin
          drive_w(9'h100, 1'b1, 1'b0, 1'b0);
          exp_q.push_back(pack(1, 0, 1, (i == 3), (i == 3) ? 2'b10 : 2'b00, i, 0));
        end else begin
          drive_w(9'h000, 1'b0, 1'b0, 1'b0);
          exp_q.push_back(pack(0, 0, (c < 4), 0, 2'b00, i, 0));
        end
        tick();
        got = obs_w(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
          miscompares++;
          $display("[TB] FAIL w_left%0d_c%0d: got %h want %h", i, c, got, want);
        end
        if (i == 3) break;
      end
    end
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       drive_w(9'h000, 1'b0, 1'b0, 1'b0);
        1:       drive_w(9'h001, 1'b0, 1'b1, 1'b0);
        default: drive_w(9'h100, 1'b1, 1'b0, 1'b0);
      endcase
      exp_q.push_back(pack(0, 0, 1, 1, 2'b10, 3, 0));
      tick();
      got = obs_w(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL w_done%0d: got %h want %h", c, got, want);
      end
    end
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive_w(9'h000, 1'b0, 1'b0, 1'b1);
        5:       drive_w(9'h100, 1'b1, 1'b0, 1'b0);
        default: drive_w(9'h000, 1'b0, 1'b0, 1'b0);
      endcase
      if (c == 5) exp_q.push_back(pack(1, 0, 1, 0, 2'b00, 1, 0));
      else        exp_q.push_back(pack(0, 0, (c < 4), 0, 2'b00, 0, 0));
      tick();
      got = obs_w(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL w_restart%0d: got %h want %h", c, got, want);
      end
    end
    drive_w(9'h000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    Reset   = 1'b1;
    Reset_w = 1'b1;
    drive_main(9'h000, 1'b0, 1'b0, 1'b0);
    drive_w(9'h000, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_left_point();
    test_gap_ignores();
    test_no_score();
    test_reset_mid_gap();
    test_seven_right();
    test_win_and_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
